uart_operand_assembler: RTL
===========================

Name: uart_operand_assembler

Overview:
- Sits directly downstream of the UART receiver and consumes its byte output (`uart_d_out` / `uart_valid`).
- Collects bytes into a framed command, checks its XOR checksum, and presents two operands to the multiplier datapath over a valid/ready handshake.
- Detects inter-byte timeout and output overrun, and reports both through error status.

Parameters:
- OP_BYTES, 2, bytes per operand; each operand is 8*OP_BYTES bits, sent MSB byte first.
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CYCLES, 24'd104160, maximum idle clocks between bytes inside a frame (2 byte-times at 9600 baud, 50 MHz).

Ports:
- uart_clock  in  1  system clock
- uart_reset  in  1  asynchronous active-low reset
- rx_data  in  8  byte from UART receiver (its uart_d_out)
- rx_valid  in  1  receiver valid level (its uart_valid)
- op_a  out  8*OP_BYTES  operand A
- op_b  out  8*OP_BYTES  operand B
- op_valid  out  1  operands available
- op_ready  in  1  consumer accepts operands
- frame_error  out  1  one-cycle pulse on a rejected frame
- error_code  out  2  cause of last error, held: 01 checksum, 10 timeout, 11 overrun

Behaviour:
- Clock and reset: one clock, uart_clock. Reset uart_reset is asynchronous, active-low.
- Reset values: op_a=0, op_b=0, op_valid=0, frame_error=0, error_code=00. All internal registers clear and state returns to IDLE. Reset mid-frame discards the partial frame.
- Byte strobe: rx_valid is a level that stays high between bytes. Register it as rx_valid_q (reset 0).
  - byte_stb = rx_valid & ~rx_valid_q.
  - Exactly one strobe per received byte.
  - rx_data is sampled in the strobe cycle.
- Frame format: HEADER, A[MSB..LSB], B[MSB..LSB], CHK.
  - CHK is the XOR of all 2*OP_BYTES payload bytes; HEADER is excluded.
- States:
  - IDLE: on byte_stb with rx_data==HEADER, go to LOAD_A and clear byte_cnt, checksum accumulator, timeout counter. Non-header bytes are ignored silently (no error).
  - LOAD_A: each byte_stb shifts rx_data into the A shadow register (shift left by 8) and XORs it into the accumulator. After OP_BYTES bytes, go to LOAD_B.
  - LOAD_B: same handling into the B shadow register. After OP_BYTES bytes, go to CHECK_BYTE.
  - CHECK_BYTE: on byte_stb, compare rx_data with the accumulator, then go to IDLE.
  - A HEADER value received inside LOAD_A, LOAD_B or CHECK_BYTE is data; there is no resync.
- Commit (checksum match at strobe cycle T):
  - If op_valid==0, or op_valid & op_ready in cycle T: load op_a/op_b from the shadows. op_valid=1 is visible at T+1. Latency is one clock from the checksum strobe.
  - Otherwise (output still pending): keep the outputs, pulse frame_error at T+1, error_code=11.
- Checksum mismatch: outputs unchanged, frame_error pulse at T+1, error_code=01.
- Handshake:
  - op_valid stays high and op_a/op_b stay stable until op_valid & op_ready.
  - op_valid falls the cycle after acceptance, unless a new commit occurs in the same cycle, in which case it stays high with the new data.
- Timeout:
  - In LOAD_A, LOAD_B and CHECK_BYTE the counter increments every cycle and clears on each byte_stb.
  - When the counter reaches TIMEOUT_CYCLES-1 with no strobe: go to IDLE, pulse frame_error, error_code=10.
  - A strobe in the same cycle wins; no timeout.
  - The counter is held at 0 in IDLE.
- error_code holds its value until the next error; successful frames do not clear it.
- Assembly continues while op_valid is pending, because the shadow registers are separate from the output registers.

Test Plan:
- Frame A5 12 34 56 78 08 at 9600 baud through uart_rx -> op_a=16'h1234, op_b=16'h5678, op_valid=1 one clock after the CHK strobe, frame_error never pulses.
- Same frame with CHK=09 -> frame_error pulse of 1 cycle, error_code=01, op_valid stays 0, op_a/op_b stay 0.
- Send A5 12 34 then silence -> frame_error pulse exactly TIMEOUT_CYCLES cycles after the 34 strobe, error_code=10; the next valid frame is then accepted normally.
- Leading junk 00 FF 5A then a valid frame -> junk ignored, no error, op_a/op_b correct.
- op_ready held 0; send two valid frames (second: A5 00 03 00 05 06) -> first operands held, overrun error_code=11. Then raise op_ready for 1 cycle -> op_valid falls next cycle.
- Assert uart_reset after A5 12 -> all outputs 0. Then a full valid frame -> op_valid=1 with correct operands. Also check the op_ready pulse coinciding with a commit: op_valid stays 1 with the new data.

Source files
------------

// File: rtl/uart_operand_assembler.sv
// Frames UART bytes into two checksummed operands for the multiplier,
// with inter-byte timeout and output overrun reporting.
module uart_operand_assembler #(
  parameter int          OP_BYTES       = 2,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd104160
) (
  input  logic                  uart_clock,
  input  logic                  uart_reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [8*OP_BYTES-1:0] op_a,
  output logic [8*OP_BYTES-1:0] op_b,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic                  frame_error,
  output logic [1:0]            error_code
);

  localparam int W  = 8 * OP_BYTES;
  localparam int CW = $clog2(OP_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CHECK_BYTE
  } state_t;

  state_t         state_q;
  logic           rx_valid_q;
  logic [CW-1:0]  byte_cnt_q;
  logic [7:0]     acc_q;
  logic [23:0]    tmo_q;
  logic [W-1:0]   sha_q;
  logic [W-1:0]   shb_q;
  logic [W-1:0]   op_a_q;
  logic [W-1:0]   op_b_q;
  logic           op_valid_q;
  logic           frame_error_q;
  logic [1:0]     error_code_q;

  logic           byte_stb;
  logic           last_byte;
  logic           tmo_hit;
  logic           can_load;
  logic [W-1:0]   sha_d;
  logic [W-1:0]   shb_d;

  assign byte_stb  = rx_valid & ~rx_valid_q;
  assign last_byte = byte_cnt_q == CW'(OP_BYTES - 1);
  assign tmo_hit   = tmo_q == TIMEOUT_CYCLES - 24'd1;
  assign can_load  = ~op_valid_q | op_ready;
  assign sha_d     = (sha_q << 8) | W'(rx_data);
  assign shb_d     = (shb_q << 8) | W'(rx_data);

  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      state_q       <= IDLE;
      rx_valid_q    <= 1'b0;
      byte_cnt_q    <= '0;
      acc_q         <= '0;
      tmo_q         <= '0;
      sha_q         <= '0;
      shb_q         <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      error_code_q  <= 2'b00;
    end else begin
      rx_valid_q    <= rx_valid;
      frame_error_q <= 1'b0;
      if (op_valid_q && op_ready)
        op_valid_q <= 1'b0;

      if (state_q == IDLE) begin
        tmo_q <= '0;
        if (byte_stb && rx_data == HEADER) begin
          state_q    <= LOAD_A;
          byte_cnt_q <= '0;
          acc_q      <= '0;
        end
      end else if (!byte_stb) begin
        if (tmo_hit) begin
          state_q       <= IDLE;
          frame_error_q <= 1'b1;
          error_code_q  <= 2'b10;
        end else begin
          tmo_q <= tmo_q + 24'd1;
        end
      end else begin
        tmo_q <= '0;
        case (state_q)
          LOAD_A: begin
            sha_q      <= sha_d;
            acc_q      <= acc_q ^ rx_data;
            byte_cnt_q <= last_byte ? '0 : byte_cnt_q + CW'(1);
            if (last_byte)
              state_q <= LOAD_B;
          end
          LOAD_B: begin
            shb_q      <= shb_d;
            acc_q      <= acc_q ^ rx_data;
            byte_cnt_q <= last_byte ? '0 : byte_cnt_q + CW'(1);
            if (last_byte)
              state_q <= CHECK_BYTE;
          end
          CHECK_BYTE: begin
            state_q <= IDLE;
            if (rx_data != acc_q) begin
              frame_error_q <= 1'b1;
              error_code_q  <= 2'b01;
            end else if (can_load) begin
              // a commit overrides a same-cycle acceptance
              op_a_q     <= sha_q;
              op_b_q     <= shb_q;
              op_valid_q <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
              error_code_q  <= 2'b11;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_valid    = op_valid_q;
  assign frame_error = frame_error_q;
  assign error_code  = error_code_q;

endmodule
